end_screen_ctrl: RTL

END_SCREEN_CTRL -- requirements
Module: end_screen_ctrl

---
 rtl/snake_pkg.sv | 17 +
 rtl/button_hit.sv | 20 ++
 rtl/end_screen_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared snake game types and end-screen button geometry.
// Used by the drawing chains and the screen controller.
package snake_pkg;

  typedef enum logic [1:0] {
    SCR_MENU = 2'd0,
    SCR_GAME = 2'd1,
    SCR_WIN  = 2'd2,
    SCR_LOSE = 2'd3
  } screen_t;

  localparam logic [11:0] BUTTONS_X = 12'd412;
  localparam logic [11:0] BUTTONE_Y = 12'd560;
  localparam logic [11:0] BUTTONS_W = 12'd200;
  localparam logic [11:0] BUTTONS_H = 12'd64;

endpackage

// File: rtl/button_hit.sv
// Combinational rectangle hit test on a 12-bit pointer position.
// Edges are inclusive on all four sides.
module button_hit #(
  parameter logic [11:0] X = 12'd1,
  parameter logic [11:0] Y = 12'd1,
  parameter logic [11:0] W = 12'd1,
  parameter logic [11:0] H = 12'd1
) (
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic        hit
);

  localparam logic [11:0] X_HI = X + W - 12'd1;
  localparam logic [11:0] Y_HI = Y + H - 12'd1;

  assign hit = (xpos >= X) && (xpos <= X_HI) &&
               (ypos >= Y) && (ypos <= Y_HI);

endmodule

// File: rtl/end_screen_ctrl.sv
// Menu / game / end-screen sequencer with a timed input lockout
// and a clickable "back to menu" button on the end screen.
module end_screen_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 32_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic        game_over,
  input  logic        game_won,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  output screen_t     screen,
  output logic        menu_req,
  output logic        end_armed
);

  localparam int CLOG = $clog2(HOLD_CYCLES + 1);
  localparam int CW   = (CLOG < 1) ? 1 : CLOG;
  localparam logic [CW-1:0] CNT_LAST =
    (HOLD_CYCLES < 2) ? '0 : CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_MENU,
    ST_GAME,
    ST_END_HOLD,
    ST_END_ARMED
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          won_q, won_d;
  logic          ml_q;
  screen_t       screen_q, screen_d;
  logic          menu_req_q, menu_req_d;
  logic          armed_q, armed_d;
  logic          hit, click;

  button_hit #(
    .X(BUTTONS_X),
    .Y(BUTTONE_Y),
    .W(BUTTONS_W),
    .H(BUTTONS_H)
  ) u_hit (
    .xpos(xpos),
    .ypos(ypos),
    .hit (hit)
  );

  assign click = mouse_left & ~ml_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    won_d      = won_q;
    menu_req_d = 1'b0;
    unique case (state_q)
      ST_MENU: begin
        if (start_game) state_d = ST_GAME;
      end
      ST_GAME: begin
        if (game_over) begin
          won_d   = game_won;
          cnt_d   = '0;
          state_d = ST_END_HOLD;
        end
      end
      ST_END_HOLD: begin
        if (cnt_q == CNT_LAST) state_d = ST_END_ARMED;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_END_ARMED: begin
        if (click && hit) begin
          state_d    = ST_MENU;
          menu_req_d = 1'b1;
        end
      end
      default: state_d = ST_MENU;
    endcase

    // outputs follow the next state so they flip with the state flop
    unique case (state_d)
      ST_MENU: screen_d = SCR_MENU;
      ST_GAME: screen_d = SCR_GAME;
      default: screen_d = won_d ? SCR_WIN : SCR_LOSE;
    endcase
    armed_d = (state_d == ST_END_ARMED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_MENU;
      cnt_q      <= '0;
      won_q      <= 1'b0;
      ml_q       <= 1'b0;
      screen_q   <= SCR_MENU;
      menu_req_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      won_q      <= won_d;
      ml_q       <= mouse_left;
      screen_q   <= screen_d;
      menu_req_q <= menu_req_d;
      armed_q    <= armed_d;
    end
  end

  assign screen    = screen_q;
  assign menu_req  = menu_req_q;
  assign end_armed = armed_q;

endmodule
